cache_ctrl_nway2: RTL and testbench

Parametrised two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and a line-wide memory backend. It generalises line size and set count. It adds update-on-write-hit instead of invalidation, same-cycle bypass of fill data, and a sequential flush sweep. A stall signal holds the pipeline while a fill, write or flush is in progress.

---
 rtl/cache_ctrl_nway2.sv | 194 +++++++++++++++++++
 tb/tb_cache_ctrl_nway2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_nway2.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete in one cycle; fills, writes and flush sweeps stall the pipeline.
module cache_ctrl_nway2 #(
    parameter int ADDR_W     = 18,
    parameter int INDEX_W    = 6,
    parameter int LINE_WORDS = 2,
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = ADDR_W - INDEX_W - OFF_W - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [31:0]              data_in,
    input  logic                     MEM_R_en,
    input  logic                     MEM_W_en,
    input  logic                     flush,
    output logic [31:0]              data_out,
    output logic                     freeze,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                     mem_ready
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_FLUSH} state_e;

    state_e               state_q, state_d;
    logic                 flush_q, flush_d;
    logic [INDEX_W-1:0]   cnt_q, cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;

    logic [SETS-1:0]      valid_q [2];
    logic [SETS-1:0]      lru_q;
    logic [TAG_W-1:0]     tag_q   [2][SETS];
    logic [31:0]          line_q  [2][SETS][LINE_WORDS];

    logic [OFF_W-1:0]     word;
    logic [INDEX_W-1:0]   index;
    logic [TAG_W-1:0]     tag;
    logic [ADDR_W-1:0]    line_addr;
    logic [LINE_WORDS-1:0][31:0] fill_words;

    logic                 hit0, hit1, hit_any, hit_way, victim, flush_pend;
    logic                 fill_we, word_we, lru_we, lru_new, clr_set;

    assign word       = addr[OFF_W+1:2];
    assign index      = addr[OFF_W+INDEX_W+1:OFF_W+2];
    assign tag        = addr[ADDR_W-1:ADDR_W-TAG_W];
    assign line_addr  = {addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    assign fill_words = mem_rdata;

    // Way 0 wins if both ways ever claim the same tag.
    assign hit0       = valid_q[0][index] && (tag_q[0][index] == tag);
    assign hit1       = valid_q[1][index] && (tag_q[1][index] == tag);
    assign hit_any    = hit0 | hit1;
    assign hit_way    = ~hit0;
    assign victim     = lru_q[index];
    assign flush_pend = flush_q | flush;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        freeze      = 1'b0;
        data_out    = '0;
        fill_we     = 1'b0;
        word_we     = 1'b0;
        lru_we      = 1'b0;
        lru_new     = 1'b0;
        clr_set     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush_pend) begin
                    freeze  = 1'b1;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else if (MEM_W_en) begin
                    freeze      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr;
                    mem_wdata_d = data_in;
                    state_d     = S_WRITE;
                end else if (MEM_R_en) begin
                    if (hit_any) begin
                        data_out = line_q[hit_way][index][word];
                        lru_we   = 1'b1;
                        lru_new  = ~hit_way;
                    end else begin
                        freeze     = 1'b1;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr;
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: begin
                freeze = ~mem_ready;
                if (flush) flush_d = 1'b1;
                if (mem_ready) begin
                    data_out  = fill_words[word];
                    fill_we   = 1'b1;
                    lru_we    = 1'b1;
                    lru_new   = ~victim;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WRITE: begin
                freeze = ~mem_ready;
                if (flush) flush_d = 1'b1;
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_IDLE;
                    if (hit_any) begin
                        word_we = 1'b1;
                        lru_we  = 1'b1;
                        lru_new = ~hit_way;
                    end
                end
            end
            S_FLUSH: begin
                freeze  = 1'b1;
                clr_set = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q[0]  <= '0;
            valid_q[1]  <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (clr_set) begin
                valid_q[0][cnt_q] <= 1'b0;
                valid_q[1][cnt_q] <= 1'b0;
                lru_q[cnt_q]      <= 1'b0;
            end
            if (fill_we) valid_q[victim][index] <= 1'b1;
            if (lru_we)  lru_q[index]           <= lru_new;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide whether their contents are trusted.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim][index] <= tag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[victim][index][k] <= fill_words[k];
            end
        end
        if (word_we) line_q[hit_way][index][word] <= data_in;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl_nway2.sv
// Directed bench for cache_ctrl_nway2: hit table plus hand-written miss, write,
// flush and reset sequences. Inputs change 1ns after posedge, outputs sampled on negedge.
module tb_cache_ctrl_nway2;
    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic [31:0] data_in;
    logic        MEM_R_en, MEM_W_en, flush;
    logic [31:0] data_out;
    logic        freeze, mem_req, mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;

    int total  = 0;
    int passed = 0;

    cache_ctrl_nway2 dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en), .flush(flush),
        .data_out(data_out), .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    localparam logic [63:0] LINE_1 = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    localparam logic [63:0] LINE_A = {32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [63:0] LINE_B = {32'hB1B1_0001, 32'hB0B0_0000};
    localparam logic [63:0] LINE_C = {32'hC1C1_0001, 32'hC0C0_0000};
    localparam logic [63:0] LINE_D = {32'hD1D1_0001, 32'hD0D0_0000};
    localparam logic [63:0] LINE_E = {32'hE1E1_0001, 32'hE0E0_0000};
    localparam logic [63:0] LINE_F = {32'hF1F1_0001, 32'hF0F0_0000};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_miss(input string nm, input logic [17:0] a, input logic [63:0] line, input int lat);
        logic [31:0] exp_w;
        exp_w    = a[2] ? line[63:32] : line[31:0];
        MEM_R_en = 1'b1;
        addr     = a;
        @(negedge clk);
        check({nm, "_miss_freeze"}, 32'(freeze), 32'd1);
        tick();
        @(negedge clk);
        check({nm, "_req"}, 32'(mem_req), 32'd1);
        check({nm, "_we"}, 32'(mem_we), 32'd0);
        check({nm, "_addr"}, 32'(mem_addr), 32'({a[17:3], 3'b000}));
        tick();
        for (int i = 1; i < lat; i++) tick();
        mem_ready = 1'b1;
        mem_rdata = line;
        @(negedge clk);
        check({nm, "_fill_freeze"}, 32'(freeze), 32'd0);
        check({nm, "_bypass"}, data_out, exp_w);
        tick();
        mem_ready = 1'b0;
        MEM_R_en  = 1'b0;
        @(negedge clk);
        check({nm, "_req_drop"}, 32'(mem_req), 32'd0);
        tick();
    endtask

    task automatic read_hit(input string nm, input logic [17:0] a, input logic [31:0] exp);
        MEM_R_en = 1'b1;
        addr     = a;
        @(negedge clk);
        check({nm, "_hit_freeze"}, 32'(freeze), 32'd0);
        check({nm, "_hit_data"}, data_out, exp);
        tick();
        MEM_R_en = 1'b0;
    endtask

    task automatic do_write(input string nm, input logic [17:0] a, input logic [31:0] d, input int lat);
        MEM_W_en = 1'b1;
        addr     = a;
        data_in  = d;
        @(negedge clk);
        check({nm, "_freeze"}, 32'(freeze), 32'd1);
        tick();
        @(negedge clk);
        check({nm, "_req"}, 32'(mem_req), 32'd1);
        check({nm, "_we"}, 32'(mem_we), 32'd1);
        check({nm, "_addr"}, 32'(mem_addr), 32'(a));
        check({nm, "_wdata"}, mem_wdata, d);
        tick();
        for (int i = 1; i < lat; i++) tick();
        mem_ready = 1'b1;
        @(negedge clk);
        check({nm, "_release"}, 32'(freeze), 32'd0);
        tick();
        mem_ready = 1'b0;
        MEM_W_en  = 1'b0;
        @(negedge clk);
        check({nm, "_req_drop"}, 32'(mem_req), 32'd0);
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1; addr = '0; data_in = '0; MEM_R_en = 1'b0; MEM_W_en = 1'b0;
        flush = 1'b0; mem_rdata = '0; mem_ready = 1'b0;

        // Reset state.
        tick(); tick();
        @(negedge clk);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_dout", data_out, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // First miss with bypass, then a hit on the other word of the line.
        read_miss("rd10", 18'h00010, LINE_1, 2);
        read_hit("rd14", 18'h00014, 32'hBBBB_BBBB);

        // LRU replacement at index 3: C evicts A, B survives, A misses again.
        read_miss("fillA", 18'h00018, LINE_A, 1);
        read_miss("fillB", 18'h00218, LINE_B, 3);
        read_miss("fillC", 18'h00418, LINE_C, 1);
        read_hit("reB", 18'h00218, 32'hB0B0_0000);
        read_miss("reA", 18'h00018, LINE_A, 2);

        vecs[0] = '{18'h00010, 32'hAAAA_AAAA};
        vecs[1] = '{18'h00014, 32'hBBBB_BBBB};
        vecs[2] = '{18'h00218, 32'hB0B0_0000};
        vecs[3] = '{18'h0021C, 32'hB1B1_0001};
        vecs[4] = '{18'h00018, 32'hA0A0_0000};
        vecs[5] = '{18'h0001C, 32'hA1A1_0001};
        for (int i = 0; i < 6; i++) begin
            read_hit($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Write hit updates the cached word in place.
        do_write("wr_hit", 18'h00014, 32'h1234_5678, 2);
        read_hit("rd_after_wr", 18'h00014, 32'h1234_5678);
        read_hit("rd_neighbor", 18'h00010, 32'hAAAA_AAAA);

        // Write miss goes to the backend but does not allocate.
        do_write("wr_miss", 18'h30000, 32'hCAFE_F00D, 1);
        read_miss("rd_no_alloc", 18'h30000, LINE_D, 1);

        // Flush pulse during a fill: fill finishes, then the sweep stalls the pipeline.
        MEM_R_en = 1'b1;
        addr     = 18'h00800;
        @(negedge clk);
        check("fl_miss_freeze", 32'(freeze), 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        mem_ready = 1'b1;
        mem_rdata = LINE_E;
        @(negedge clk);
        check("fl_fill_freeze", 32'(freeze), 32'd0);
        check("fl_fill_data", data_out, 32'hE0E0_0000);
        tick();
        mem_ready = 1'b0;
        MEM_R_en  = 1'b0;
        n = 0;
        @(negedge clk);
        while (freeze === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n >= 64 && n <= 65) passed++;
        else $display("FAIL flush_stall_cycles: got %0d, expected 64..65", n);
        tick();
        read_miss("post_flush", 18'h00014, LINE_F, 1);

        // Reset in the middle of a fill aborts it; a late mem_ready must not allocate.
        MEM_R_en = 1'b1;
        addr     = 18'h00218;
        @(negedge clk);
        check("rf_miss_freeze", 32'(freeze), 32'd1);
        tick();
        @(negedge clk);
        check("rf_req", 32'(mem_req), 32'd1);
        tick();
        rst      = 1'b1;
        MEM_R_en = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rf_req_drop", 32'(mem_req), 32'd0);
        check("rf_freeze", 32'(freeze), 32'd0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = LINE_C;
        tick();
        mem_ready = 1'b0;
        read_miss("post_rst", 18'h00218, LINE_B, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
